car_direction_detector: RTL and testbench

Converts the two raw parking-lot beam sensors (outer beam A, inner beam B) into one-cycle `inc`/`dec` pulses for the car counter. It sits between the gate photosensors and the counter's `inc`/`dec` inputs. A car entering breaks A, then A+B, then B, then clears; a car exiting produces the reverse sequence. The block synchronises and debounces both sensors, tracks the sequence in an FSM, and flags illegal sequences.

---
 rtl/parking_pkg.sv | 23 ++
 rtl/sensor_debounce.sv | 58 +++++
 rtl/car_direction_detector.sv | 118 +++++++++++
 tb/tb_car_direction_detector.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module  : parking_pkg
// Brief   : Shared detector state encoding and synchroniser depth.
// Revision: 1.0
// ============================================================================
package parking_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN1   = 3'd1,
        EN2   = 3'd2,
        EN3   = 3'd3,
        EX1   = 3'd4,
        EX2   = 3'd5,
        EX3   = 3'd6,
        FAULT = 3'd7
    } det_state_t;

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module  : sensor_debounce
// Brief   : Synchroniser plus saturating debounce counter for one beam sensor.
// Revision: 1.0
// ============================================================================
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   w_synced;

    assign w_synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d  = '0;
        dout_d = dout_q;
        // Count mismatching cycles; flip only once the count has already
        // reached the limit, so any shorter mismatch falls back to zero.
        if (w_synced != dout_q) begin
            if (cnt_q == CNT_MAX) begin
                dout_d = w_synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/car_direction_detector.sv
`default_nettype none
// ============================================================================
// Module  : car_direction_detector
// Brief   : Beam-sequence FSM turning debounced A/B sensors into inc/dec pulses.
// Revision: 1.0
// ============================================================================
module car_direction_detector
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic inc,
    output logic dec,
    output logic seq_err,
    output logic busy
);

    logic       w_a, w_b;
    logic [1:0] w_ab;

    det_state_t state_q, state_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       seq_err_q, seq_err_d;
    logic       busy_q;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sensor_a),
        .dout (w_a)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sensor_b),
        .dout (w_b)
    );

    assign w_ab = {w_a, w_b};

    always_comb begin
        state_d   = state_q;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        seq_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_ab == 2'b10)      state_d = EN1;
                else if (w_ab == 2'b01) state_d = EX1;
                else if (w_ab == 2'b11) begin state_d = FAULT; seq_err_d = 1'b1; end
            end
            EN1: begin
                if (w_ab == 2'b11)      state_d = EN2;
                else if (w_ab == 2'b00) state_d = IDLE;
                else if (w_ab == 2'b01) begin state_d = FAULT; seq_err_d = 1'b1; end
            end
            EN2: begin
                if (w_ab == 2'b01)      state_d = EN3;
                else if (w_ab == 2'b10) state_d = EN1;
                else if (w_ab == 2'b00) begin state_d = FAULT; seq_err_d = 1'b1; end
            end
            EN3: begin
                if (w_ab == 2'b00)      begin state_d = IDLE; inc_d = 1'b1; end
                else if (w_ab == 2'b11) state_d = EN2;
                else if (w_ab == 2'b10) begin state_d = FAULT; seq_err_d = 1'b1; end
            end
            EX1: begin
                if (w_ab == 2'b11)      state_d = EX2;
                else if (w_ab == 2'b00) state_d = IDLE;
                else if (w_ab == 2'b10) begin state_d = FAULT; seq_err_d = 1'b1; end
            end
            EX2: begin
                if (w_ab == 2'b10)      state_d = EX3;
                else if (w_ab == 2'b01) state_d = EX1;
                else if (w_ab == 2'b00) begin state_d = FAULT; seq_err_d = 1'b1; end
            end
            EX3: begin
                if (w_ab == 2'b00)      begin state_d = IDLE; dec_d = 1'b1; end
                else if (w_ab == 2'b11) state_d = EX2;
                else if (w_ab == 2'b01) begin state_d = FAULT; seq_err_d = 1'b1; end
            end
            FAULT: begin
                if (w_ab == 2'b00)      state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // busy is registered from the next state so it always matches state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            seq_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            seq_err_q <= seq_err_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign inc     = inc_q;
    assign dec     = dec_q;
    assign seq_err = seq_err_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_car_direction_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_car_direction_detector
// Brief   : Directed scenarios for the car direction detector.
// Revision: 1.0
// ============================================================================
module tb_car_direction_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic inc, dec, seq_err, busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int inc_n, dec_n, err_n, multi_n;
    int inc_at, dec_at, busy_at, drv_at;
    bit busy_seen;

    car_direction_detector #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sensor_a(sensor_a),
        .sensor_b(sensor_b),
        .inc     (inc),
        .dec     (dec),
        .seq_err (seq_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        inc_n = 0; dec_n = 0; err_n = 0; multi_n = 0;
        inc_at = -1; dec_at = -1; busy_at = -1;
        busy_seen = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (inc)     begin inc_n++; inc_at = cyc; end
        if (dec)     begin dec_n++; dec_at = cyc; end
        if (seq_err) err_n++;
        if (busy && !busy_seen) begin busy_seen = 1'b1; busy_at = cyc; end
        if (int'(inc) + int'(dec) + int'(seq_err) > 1) multi_n++;
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        drv_at = cyc;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({inc, dec, seq_err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b need 0000", {inc, dec, seq_err, busy});
        end
        rst_n = 1'b1;
        clear_counts();
        repeat (10) tick();
        checks++;
        if (busy_seen || inc_n != 0 || dec_n != 0 || err_n != 0) begin
            errors++;
            $display("FAIL reset_idle busy_seen %0d inc %0d dec %0d err %0d need all 0",
                     busy_seen, inc_n, dec_n, err_n);
        end
    endtask

    task automatic test_entry();
        clear_counts();
        hold(1, 0, 10);
        hold(1, 1, 10);
        hold(0, 1, 10);
        hold(0, 0, 10);
        checks++;
        if (inc_n != 1 || dec_n != 0 || err_n != 0) begin
            errors++;
            $display("FAIL entry_counts inc %0d dec %0d err %0d need 1 0 0", inc_n, dec_n, err_n);
        end
        checks++;
        if (inc_at - drv_at != 8) begin
            errors++;
            $display("FAIL entry_latency got %0d need 8 samples after drive", inc_at - drv_at);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL entry_busy_end got %b need 0", busy);
        end
    endtask

    task automatic test_exit();
        int b_at;
        clear_counts();
        hold(0, 1, 10);
        b_at = drv_at;
        hold(1, 1, 10);
        hold(1, 0, 10);
        hold(0, 0, 10);
        checks++;
        if (dec_n != 1 || inc_n != 0 || err_n != 0) begin
            errors++;
            $display("FAIL exit_counts dec %0d inc %0d err %0d need 1 0 0", dec_n, inc_n, err_n);
        end
        checks++;
        if (busy_at - b_at != 8) begin
            errors++;
            $display("FAIL exit_busy_rise got %0d need 8 samples after B", busy_at - b_at);
        end
        checks++;
        if (dec_at - drv_at != 8) begin
            errors++;
            $display("FAIL exit_latency got %0d need 8", dec_at - drv_at);
        end
    endtask

    task automatic test_backout();
        clear_counts();
        hold(1, 0, 10);
        hold(1, 1, 10);
        hold(1, 0, 10);
        hold(0, 0, 10);
        checks++;
        if (inc_n != 0 || dec_n != 0 || err_n != 0 || !busy_seen) begin
            errors++;
            $display("FAIL backout_counts inc %0d dec %0d err %0d busy_seen %0d need 0 0 0 1",
                     inc_n, dec_n, err_n, busy_seen);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL backout_idle busy %b need 0", busy);
        end
    endtask

    task automatic test_illegal();
        clear_counts();
        hold(1, 1, 10);
        checks++;
        if (err_n != 1 || busy !== 1'b1 || inc_n != 0 || dec_n != 0) begin
            errors++;
            $display("FAIL illegal_err err %0d busy %b inc %0d dec %0d need 1 1 0 0",
                     err_n, busy, inc_n, dec_n);
        end
        hold(0, 0, 10);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_recover busy %b need 0", busy);
        end
        clear_counts();
        hold(1, 0, 10);
        hold(1, 1, 10);
        hold(0, 1, 10);
        hold(0, 0, 10);
        checks++;
        if (inc_n != 1 || err_n != 0) begin
            errors++;
            $display("FAIL illegal_then_entry inc %0d err %0d need 1 0", inc_n, err_n);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            hold(1, 0, 3);
            hold(0, 0, 6);
        end
        checks++;
        if (busy_seen || inc_n != 0 || dec_n != 0 || err_n != 0) begin
            errors++;
            $display("FAIL glitch_reject busy_seen %0d inc %0d dec %0d err %0d need 0 0 0 0",
                     busy_seen, inc_n, dec_n, err_n);
        end
        hold(1, 0, 5);
        hold(0, 0, 14);
        checks++;
        if (!busy_seen || inc_n != 0 || err_n != 0) begin
            errors++;
            $display("FAIL glitch_hold5 busy_seen %0d inc %0d err %0d need 1 0 0",
                     busy_seen, inc_n, err_n);
        end
    endtask

    task automatic test_reset_mid_entry();
        clear_counts();
        hold(1, 0, 10);
        hold(1, 1, 10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_entry_busy got %b need 1", busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({inc, dec, seq_err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_outputs got %b need 0000", {inc, dec, seq_err, busy});
        end
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        repeat (15) tick();
        checks++;
        if (inc_n != 0 || busy_seen) begin
            errors++;
            $display("FAIL post_reset_quiet inc %0d busy_seen %0d need 0 0", inc_n, busy_seen);
        end
        hold(0, 1, 10);
        hold(1, 1, 10);
        hold(1, 0, 10);
        hold(0, 0, 10);
        checks++;
        if (dec_n != 1 || inc_n != 0) begin
            errors++;
            $display("FAIL post_reset_exit dec %0d inc %0d need 1 0", dec_n, inc_n);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        for (int k = 0; k < 2; k++) begin
            hold(1, 0, 8);
            hold(1, 1, 8);
            hold(0, 1, 8);
            hold(0, 0, 8);
        end
        checks++;
        if (inc_n != 2 || dec_n != 0 || err_n != 0) begin
            errors++;
            $display("FAIL back_to_back inc %0d dec %0d err %0d need 2 0 0", inc_n, dec_n, err_n);
        end
        checks++;
        if (multi_n != 0) begin
            errors++;
            $display("FAIL exclusive_pulses got %0d overlaps need 0", multi_n);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_backout();
        test_illegal();
        test_glitch();
        test_reset_mid_entry();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
